// File: rtl/uart_imem_loader.sv
// UART program loader: receives 4*WORDS bytes over an 8N1 serial line and
// assembles them, little-endian per word and word 0 first, into the flat
// instruction image for the core. The core is held in reset (core_rstn low)
// until the last byte of the image has been committed.
//
//  state | meaning
//  IDLE  | line idle, waiting for a falling edge on the synchronized input
//  START | half-bit wait, then confirm the start bit is still low
//  DATA  | sample eight data bits, LSB first, one per full bit period
//  STOP  | sample the stop bit; commit the byte or flag a framing error
//  DONE  | image complete, all further line activity ignored until rst
module uart_imem_loader #(
    parameter int CLK_PER_HALF_BIT = 2604,
    parameter int WORDS            = 32,
    localparam int NBYTES          = 4 * WORDS,
    localparam int BCW             = $clog2(NBYTES + 1),
    localparam int TW              = $clog2(2 * CLK_PER_HALF_BIT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [32*WORDS-1:0]  i_memory_input,
    output logic                 loaded,
    output logic                 core_rstn,
    output logic                 frame_err,
    output logic [BCW-1:0]       byte_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [TW-1:0]  HALF_LOAD = TW'(CLK_PER_HALF_BIT - 1);
    localparam logic [TW-1:0]  FULL_LOAD = TW'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [BCW-1:0] LAST_IDX  = BCW'(NBYTES - 1);

    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           sync_1, rx_s;
    logic           commit;
    logic           set_ferr;

    // Two-flop synchronizer; resets to the idle line level so reset never
    // looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= rxd;
            rx_s   <= sync_1;
        end
    end

    // FSM state, bit timer, bit index and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic; the timer only decrements while non-zero, and every
    // expiry either reloads it or leaves the receiving states.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        commit   = 1'b0;
        set_ferr = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    timer_d = HALF_LOAD;
                end
            end
            START: begin
                if (timer_q == '0) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bit_d   = 3'd0;
                        timer_d = FULL_LOAD;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DATA: begin
                if (timer_q == '0) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    timer_d = FULL_LOAD;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            STOP: begin
                if (timer_q == '0) begin
                    if (rx_s) begin
                        commit  = 1'b1;
                        state_d = (byte_count == LAST_IDX) ? DONE : IDLE;
                    end else begin
                        set_ferr = 1'b1;
                        state_d  = IDLE;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Image, byte counter and status flags; a commit writes the byte at the
    // current count, so the count doubles as the write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_memory_input <= '0;
            byte_count     <= '0;
            loaded         <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            if (commit) begin
                i_memory_input[{byte_count, 3'b000} +: 8] <= shift_q;
                byte_count <= byte_count + 1'b1;
                if (byte_count == LAST_IDX) begin
                    loaded <= 1'b1;
                end
            end
            if (set_ferr) begin
                frame_err <= 1'b1;
            end
        end
    end

    assign core_rstn = loaded;

endmodule
